// File: rtl/ext_bus_ctrl.sv
// Bridges a 32-bit load/store request port to a 16-bit external pad bus
// as one or two half-word beats with wait states and a release cycle.
module ext_bus_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_W      = 23
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_be,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_cs_n,
    output logic              bus_we_n,
    output logic [1:0]        bus_be_n,
    output logic [15:0]       bus_data_drv_b,
    output logic              dbus_o_en_b,
    output logic              dbus_i_en_b,
    input  logic [15:0]       bus_data_recv_b
);

    typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_WAIT, ST_HOLD, ST_REL} state_t;

    localparam logic [3:0] WAIT_LAST = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t      state, next_state;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        beat;
    logic [3:0]  cnt;
    logic [15:0] rdata_lo;
    logic        accept;
    logic        more;
    logic        first_beat;
    logic        active;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:ADDR_W+1], req_addr[1:0]};

    // A write skips the low half when none of its low byte lanes are enabled.
    assign first_beat = req_we && (req_be[1:0] == 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        more       = (beat == 1'b0) && (!we_q || (be_q[3:2] != 2'b00));
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    next_state = (req_we && (req_be == 4'b0000)) ? ST_REL : ST_SETUP;
                end
            end
            ST_SETUP: next_state = (WAIT_CYCLES == 0) ? ST_HOLD : ST_WAIT;
            ST_WAIT:  if (cnt == WAIT_LAST) next_state = ST_HOLD;
            ST_HOLD:  next_state = more ? ST_SETUP : ST_REL;
            ST_REL:   next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        active      = (state == ST_SETUP) || (state == ST_WAIT) || (state == ST_HOLD);
        req_ready   = (state == ST_IDLE);
        rsp_valid   = (state == ST_REL);
        bus_cs_n    = 1'b1;
        bus_we_n    = 1'b1;
        bus_be_n    = 2'b11;
        dbus_o_en_b = 1'b0;
        dbus_i_en_b = 1'b0;
        if (active) begin
            bus_cs_n    = 1'b0;
            bus_we_n    = !we_q;
            bus_be_n    = we_q ? ~(beat ? be_q[3:2] : be_q[1:0]) : 2'b00;
            dbus_o_en_b = we_q;
            dbus_i_en_b = !we_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q           <= 1'b0;
            be_q           <= '0;
            wdata_q        <= '0;
            beat           <= 1'b0;
            cnt            <= '0;
            rdata_lo       <= '0;
            rsp_rdata      <= '0;
            bus_addr       <= '0;
            bus_data_drv_b <= '0;
        end else begin
            if (accept) begin
                we_q     <= req_we;
                be_q     <= req_be;
                wdata_q  <= req_wdata;
                beat     <= first_beat;
                bus_addr <= {req_addr[ADDR_W:2], first_beat};
                if (req_we)
                    bus_data_drv_b <= first_beat ? req_wdata[31:16] : req_wdata[15:0];
            end
            if (state == ST_SETUP)     cnt <= '0;
            else if (state == ST_WAIT) cnt <= cnt + 4'd1;
            // Reads always finish on the high beat, so the response word is
            // assembled on the edge that leaves the last HOLD.
            if (state == ST_HOLD) begin
                if (!we_q && !beat) rdata_lo  <= bus_data_recv_b;
                if (!we_q && beat)  rsp_rdata <= {bus_data_recv_b, rdata_lo};
                if (more) begin
                    beat        <= 1'b1;
                    bus_addr[0] <= 1'b1;
                    if (we_q) bus_data_drv_b <= wdata_q[31:16];
                end
            end
        end
    end

endmodule

// File: tb/tb_ext_bus_ctrl.sv
// Randomized self-checking bench for ext_bus_ctrl; one instance per
// wait-state setting, checked cycle by cycle against a transaction model.
module tb_ext_bus_ctrl;

    typedef struct packed {
        logic        ready;
        logic        rsp_valid;
        logic [31:0] rdata;
        logic [22:0] addr;
        logic        cs_n;
        logic        we_n;
        logic [1:0]  be_n;
        logic [15:0] drv;
        logic        o_en;
        logic        i_en;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rv2, rv0;
    logic [15:0] recv2, recv0;
    obs_t        o2, o0, o;
    logic [31:0] last_rd [2];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_val(input logic [22:0] a);
        logic [31:0] t;
        if (a == 23'h802) return 16'hBEEF;
        if (a == 23'h803) return 16'hDEAD;
        t = {9'b0, a} * 32'd40503 + 32'd4660;
        return t[15:0];
    endfunction

    assign rv2   = req_valid & ~sel;
    assign rv0   = req_valid & sel;
    assign recv2 = mem_val(o2.addr);
    assign recv0 = mem_val(o0.addr);
    always_comb o = sel ? o0 : o2;

    ext_bus_ctrl #(.WAIT_CYCLES(2), .ADDR_W(23)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(rv2), .req_ready(o2.ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(o2.rsp_valid), .rsp_rdata(o2.rdata), .bus_addr(o2.addr),
        .bus_cs_n(o2.cs_n), .bus_we_n(o2.we_n), .bus_be_n(o2.be_n),
        .bus_data_drv_b(o2.drv), .dbus_o_en_b(o2.o_en), .dbus_i_en_b(o2.i_en),
        .bus_data_recv_b(recv2)
    );

    ext_bus_ctrl #(.WAIT_CYCLES(0), .ADDR_W(23)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv0), .req_ready(o0.ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(o0.rsp_valid), .rsp_rdata(o0.rdata), .bus_addr(o0.addr),
        .bus_cs_n(o0.cs_n), .bus_we_n(o0.we_n), .bus_be_n(o0.be_n),
        .bus_data_drv_b(o0.drv), .dbus_o_en_b(o0.o_en), .dbus_i_en_b(o0.i_en),
        .bus_data_recv_b(recv0)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request and compare every following cycle against the
    // beat schedule derived from the request alone.
    task automatic run_txn(input bit we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be, input bit hold, input bit b2b);
        int unsigned w, lat, k, b, n;
        int unsigned bq[$];
        logic [31:0] rd_exp;
        logic [1:0]  be_half;
        logic [22:0] ea;
        w = sel ? 0 : 2;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o.ready && n < 40);
        if (!o.ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        check("idle_bus", {o.cs_n, o.we_n, o.be_n, o.o_en, o.i_en, o.rsp_valid}, 7'b1111000);
        if (b2b) check("b2b_gap", n, 1);
        req_we = we; req_addr = a; req_wdata = wd; req_be = be; req_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;

        if (!we) bq = '{0, 1};
        else begin
            if (be[1:0] != 2'b00) bq.push_back(0);
            if (be[3:2] != 2'b00) bq.push_back(1);
        end
        lat = (bq.size() == 0) ? 1 : bq.size() * (w + 2) + 1;
        rd_exp = {mem_val({a[23:2], 1'b1}), mem_val({a[23:2], 1'b0})};

        for (int unsigned c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c < lat) begin
                k = (c - 1) / (w + 2);
                b = bq[k];
                be_half = (b == 1) ? be[3:2] : be[1:0];
                ea = {a[23:2], b[0]};
                check($sformatf("c%0d_ctl", c),
                      {o.ready, o.rsp_valid, o.cs_n, o.we_n, o.be_n, o.o_en, o.i_en},
                      {1'b0, 1'b0, 1'b0, !we, we ? ~be_half : 2'b00, we, !we});
                check($sformatf("c%0d_addr", c), o.addr, ea);
                if (we) check($sformatf("c%0d_drv", c), o.drv, (b == 1) ? wd[31:16] : wd[15:0]);
            end else begin
                check("rel_ctl",
                      {o.ready, o.rsp_valid, o.cs_n, o.we_n, o.be_n, o.o_en, o.i_en},
                      8'b01111100);
                if (!we) last_rd[sel] = rd_exp;
                check("rsp_rdata", o.rdata, last_rd[sel]);
            end
        end
    endtask

    task automatic reset_mid_write();
        int unsigned n;
        bit saw;
        sel = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o.ready && n < 40);
        req_we = 1'b1; req_addr = 32'h0000_2468; req_wdata = 32'hCAFE_F00D;
        req_be = 4'hF; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_active", {o.cs_n, o.o_en}, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_bus", {o.cs_n, o.we_n, o.be_n, o.o_en, o.i_en}, 6'b111100);
        check("rst_async_rsp", {o.ready, o.rsp_valid}, 2'b10);
        check("rst_async_addr", {o.addr, o.drv}, '0);
        #1 rst_n = 1'b1;
        last_rd[0] = '0;
        last_rd[1] = '0;
        saw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (o.rsp_valid) saw = 1'b1;
        end
        check("no_rsp_after_rst", saw, 1'b0);
        check("ready_after_rst", o.ready, 1'b1);
    endtask

    initial begin
        last_rd[0] = '0;
        last_rd[1] = '0;
        #12;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check($sformatf("rst%0d_ctl", s),
                  {o.ready, o.rsp_valid, o.cs_n, o.we_n, o.be_n, o.o_en, o.i_en}, 8'b10111100);
            check($sformatf("rst%0d_data", s), {o.rdata, o.addr, o.drv}, '0);
        end
        sel = 1'b0;
        #10 rst_n = 1'b1;

        run_txn(1'b0, 32'h0000_1004, 32'h0, 4'h0, 1'b0, 1'b0);
        check("spec_read_word", o.rdata, 32'hDEAD_BEEF);
        run_txn(1'b1, 32'h0000_1008, 32'h1234_5678, 4'hF, 1'b0, 1'b0);
        run_txn(1'b1, 32'h0000_100C, 32'hA5A5_5A5A, 4'hC, 1'b0, 1'b0);
        run_txn(1'b1, 32'h0000_1010, 32'h0BAD_F00D, 4'h2, 1'b0, 1'b0);
        run_txn(1'b1, 32'h0000_1014, 32'h7777_8888, 4'h0, 1'b0, 1'b0);
        run_txn(1'b1, 32'h0000_2000, 32'h1111_2222, 4'hF, 1'b1, 1'b0);
        run_txn(1'b0, 32'h0000_2004, 32'h0, 4'h0, 1'b0, 1'b1);

        reset_mid_write();

        for (int i = 0; i < 30; i++)
            run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), 1'b0, 1'b0);

        sel = 1'b1;
        run_txn(1'b0, 32'h0000_1004, 32'h0, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++)
            run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ext_bus_ctrl.md
# ext_bus_ctrl

Bridges the core's 32-bit data-memory request port to the 16-bit external data bus carried by the north pad ring. It drives the pad-side data, output enable and input enable, and captures the pad receive data. Each 32-bit access becomes one or two half-word beats with programmable wait states and a guaranteed bus-release cycle between transactions. It sits between the load/store unit and `pads_north`.

## Interface
- `WAIT_CYCLES`, default 2: wait-state cycles inserted per beat, range 0..15.
- `ADDR_W`, default 23: width of the external half-word address.

- `clk` in 1: system clock; all logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: core request valid.
- `req_ready` out 1: request accepted on the edge where `req_valid && req_ready`.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in 32: byte address; bits [1:0] are ignored.
- `req_wdata` in 32: write data.
- `req_be` in 4: byte enables; used only for writes.
- `rsp_valid` out 1: one-cycle completion pulse for reads and writes.
- `rsp_rdata` out 32: read data, valid while `rsp_valid` is high and held afterwards.
- `bus_addr` out ADDR_W: half-word address, `{req_addr[ADDR_W:2], beat}`.
- `bus_cs_n` out 1: chip select, active low.
- `bus_we_n` out 1: write strobe, active low.
- `bus_be_n` out 2: half-word byte enables, active low.
- `bus_data_drv_b` out 16: data to the pad `DATA_OUT`.
- `dbus_o_en_b` out 1: pad output enable, active high.
- `dbus_i_en_b` out 1: pad input enable, active high.
- `bus_data_recv_b` in 16: data from the pad `DATA_IN`.

## Operation
- States:
  - IDLE
  - SETUP (S)
  - WAIT (W)
  - HOLD (H)
  - RELEASE (R)
- Beat register: 0 = low half, written/read first; 1 = high half.
- `req_ready` = 1 only in IDLE.
- On accept, latch `req_we`, `req_addr`, `req_wdata` and `req_be`, then pick the first beat:
  - Read: beats 0 and 1 are always performed.
  - Write: beat 0 only if `be[1:0]` != 0; beat 1 only if `be[3:2]` != 0.
  - Write with `be` = 0: IDLE→R directly, with no bus activity.
- Per-beat sequence is S → W×WAIT_CYCLES → H. S goes straight to H when WAIT_CYCLES = 0. The wait counter reloads in S.
- During S, W and H:
  - `bus_cs_n` = 0 and `bus_addr` is valid.
  - `bus_we_n` = !we.
  - `bus_be_n` = ~be half for writes and 2'b00 for reads.
  - Write: `dbus_o_en_b` = 1 and `bus_data_drv_b` = the selected `wdata` half.
  - Read: `dbus_i_en_b` = 1 and `dbus_o_en_b` = 0.
- Read capture: `bus_data_recv_b` is registered on the edge leaving H into `rdata[beat*16 +: 16]`.
- After H:
  - If another beat is pending, go to S with beat 1.
  - Otherwise go to R.
- In R:
  - `bus_cs_n` = 1 and `bus_we_n` = 1.
  - `bus_be_n` = 11.
  - Both pad enables = 0.
  - `rsp_valid` = 1.
  - Next state is IDLE.
- Turnaround: a new transaction cannot reach S before passing through R and IDLE. This guarantees two cycles with both pad enables low between transactions, so a write never overlaps a read.
- In IDLE, all bus outputs stay at their release values. `bus_addr` and `bus_data_drv_b` hold their last values.
- `rsp_rdata` for writes is unchanged, i.e. it keeps the last read data.

## Timing
- All outputs are registered, either as state decode or as flops. `req_ready` is decoded from the IDLE state.
- Reset values:
  - `req_ready` = 1, `rsp_valid` = 0, `rsp_rdata` = 0.
  - `bus_cs_n` = 1, `bus_we_n` = 1, `bus_be_n` = 2'b11, `bus_addr` = 0.
  - `bus_data_drv_b` = 0, `dbus_o_en_b` = 0, `dbus_i_en_b` = 0.
  - State = IDLE.
- Cycle 0 is the accept edge.
- Beat k (k = 0 or 1) occupies cycles 1 + k·(WAIT_CYCLES+2) through (k+1)·(WAIT_CYCLES+2).
- Latency from accept to `rsp_valid`:
  - Two-beat transaction: 2·WAIT_CYCLES + 5 cycles (9 at the default).
  - One-beat transaction: WAIT_CYCLES + 3 cycles (5 at the default).
  - Write with `be` = 0: 1 cycle.
- Minimum spacing between accepts: latency + 1 cycle.
- `req_*` inputs are ignored outside IDLE; holding `req_valid` high does not re-trigger an accept.
- Reset asserted mid-transaction forces all outputs to their reset values immediately and asynchronously. The pad enables drop in the same instant, and no `rsp_valid` is issued.

## Test plan
- **Reset mid-write.** Assert `rst_n` = 0 during the W state of a write beat. → `dbus_o_en_b` and `bus_cs_n` return to 0 and 1 without waiting for a clock edge. After release, `req_ready` = 1 and no `rsp_valid` occurs.
- **Full read, WAIT_CYCLES = 2.** Read at `req_addr` 0x0000_1004, with bus model returning 0xBEEF for beat 0 and 0xDEAD for beat 1.
  - `bus_addr` = 0x802 in cycles 1–4 and 0x803 in cycles 5–8.
  - `dbus_i_en_b` = 1 in cycles 1–8.
  - `rsp_valid` pulses in cycle 9 with `rsp_rdata` = 0xDEADBEEF.
- **Full write.** Write with `wdata` = 0x1234_5678 and `be` = 1111.
  - `bus_data_drv_b` = 0x5678, then 0x1234.
  - `dbus_o_en_b` = 1 in cycles 1–8, and `bus_we_n` = 0.
  - `rsp_valid` in cycle 9.
- **Sparse write-enable cases.**
  - `be` = 1100: single beat only, `bus_addr` LSB = 1, `bus_be_n` = 00, `rsp_valid` in cycle 5.
  - `be` = 0010: `bus_be_n` = 01.
  - `be` = 0000: no `bus_cs_n` assertion, `rsp_valid` in cycle 1.
- **Back-to-back write→read.** Hold `req_valid` high for a write followed by a read. → At least two cycles with `dbus_o_en_b` = 0 and `dbus_i_en_b` = 0 separate the write's last H and the read's S, and the second accept happens exactly one cycle after R.
- **WAIT_CYCLES = 0.** Run a two-beat read. → Each beat is 2 cycles (S, H), and `rsp_valid` arrives in cycle 5.
